// File: rtl/burst_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : burst_bus_if
//  Purpose  : SDRAM-style burst bus. Commands (read/write) with a fixed beat
//             count, write data beats following the accept cycle, read data
//             returned later as rd_data_valid pulses in command order.
//  Revision : 1.0  initial release
// ============================================================================
interface burst_bus_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int MASK_W = DATA_W / 8
);
  logic              cmd_en;
  logic              cmd;            // 1 = write, 0 = read
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [MASK_W-1:0] data_mask;
  logic              ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;

  // Requester side: issues commands and write beats, receives read data.
  modport master (
    output cmd_en, cmd, addr, wr_data, data_mask,
    input  ready, rd_data, rd_data_valid
  );

  // Responder side: accepts commands, returns read data.
  modport slave (
    input  cmd_en, cmd, addr, wr_data, data_mask,
    output ready, rd_data, rd_data_valid
  );
endinterface
`default_nettype wire

// File: rtl/burst_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : burst_bus_arbiter
//  Purpose  : Shares one burst-bus memory controller port between two
//             requesters (port 0 video scanout, port 1 debug/CPU writer).
//             Arbitrates commands, locks the bus for the data beats of a
//             write burst and steers returning read beats to the requester
//             that issued the read using an owner-tag FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module burst_bus_arbiter #(
  parameter int BURST_BEATS     = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIXED_PRIORITY  = 0
) (
  input  wire logic                             clk,
  input  wire logic                             reset_n,
  burst_bus_if.slave                            m0,
  burst_bus_if.slave                            m1,
  burst_bus_if.master                           mem,
  output logic                                  owner,
  output logic [$clog2(MAX_OUTSTANDING):0]      outstanding,
  output logic                                  protocol_error
);

  localparam int BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    ST_IDLE        = 1'b0,
    ST_WRITE_BEATS = 1'b1
  } state_t;

  // Registered state
  state_t                     state_q, state_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;          // write beat index
  logic                       owner_q, owner_d;        // last granted port
  logic                       prefer_q, prefer_d;      // port favoured on a tie
  logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;            // owner of each queued read
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;        // reads awaiting data
  logic [BEAT_W-1:0]          ret_beat_q, ret_beat_d;  // read return beat index
  logic                       perr_q, perr_d;

  // Combinational arbitration / FIFO status
  logic fifo_empty;
  logic fifo_full;
  logic head_tag;
  logic ret_valid;
  logic pop;
  logic elig0;
  logic elig1;
  logic win;
  logic win_elig;
  logic win_cmd;
  logic idle;
  logic accept;
  logic push;
  logic data_sel;

  // Pick the winning requester and derive FIFO push/pop for this cycle.
  always_comb begin
    fifo_empty = (count_q == '0);
    head_tag   = tag_q[rd_ptr_q];
    ret_valid  = mem.rd_data_valid && !fifo_empty;
    pop        = ret_valid && (ret_beat_q == LAST_BEAT);
    // A pop this cycle frees its slot, so a full FIFO can take a new read now.
    fifo_full  = (count_q == FULL_CNT) && !pop;
    elig0      = m0.cmd_en && (m0.cmd || !fifo_full);
    elig1      = m1.cmd_en && (m1.cmd || !fifo_full);
    if (FIXED_PRIORITY != 0) begin
      win = !elig0 && elig1;
    end else if (elig0 && elig1) begin
      win = prefer_q;
    end else begin
      win = elig1;
    end
    win_elig = win ? elig1 : elig0;
    win_cmd  = win ? m1.cmd : m0.cmd;
    idle     = (state_q == ST_IDLE);
    accept   = idle && win_elig && mem.ready;
    push     = accept && !win_cmd;
    // Write data follows the winner while idle, the burst owner during beats.
    data_sel = idle ? win : owner_q;
  end

  // Bus muxing toward memory and back to the requesters; all forced low in reset.
  always_comb begin
    mem.cmd_en       = 1'b0;
    mem.cmd          = 1'b0;
    mem.addr         = '0;
    mem.wr_data      = '0;
    mem.data_mask    = '0;
    m0.ready         = 1'b0;
    m1.ready         = 1'b0;
    m0.rd_data       = '0;
    m1.rd_data       = '0;
    m0.rd_data_valid = 1'b0;
    m1.rd_data_valid = 1'b0;
    if (reset_n) begin
      if (idle) begin
        mem.cmd_en = win_elig;
        mem.cmd    = win_cmd;
        mem.addr   = win ? m1.addr : m0.addr;
      end
      mem.wr_data      = data_sel ? m1.wr_data : m0.wr_data;
      mem.data_mask    = data_sel ? m1.data_mask : m0.data_mask;
      m0.ready         = idle && elig0 && !win && mem.ready;
      m1.ready         = idle && elig1 && win && mem.ready;
      m0.rd_data       = mem.rd_data;
      m1.rd_data       = mem.rd_data;
      m0.rd_data_valid = ret_valid && !head_tag;
      m1.rd_data_valid = ret_valid && head_tag;
    end
  end

  // Next-state: write-burst FSM, grant bookkeeping, tag FIFO and error flag.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    owner_d    = owner_q;
    prefer_d   = prefer_q;
    tag_d      = tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ret_beat_d = ret_beat_q;
    perr_d     = perr_q || (mem.rd_data_valid && fifo_empty);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d  = win;
          prefer_d = !win;
          if (win_cmd && (BURST_BEATS > 1)) begin
            state_d = ST_WRITE_BEATS;
            beat_d  = BEAT_W'(1);
          end
        end
      end
      ST_WRITE_BEATS: begin
        if (beat_q == LAST_BEAT) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase

    if (push) begin
      tag_d[wr_ptr_q] = win;
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end

    if (ret_valid) begin
      ret_beat_d = pop ? '0 : ret_beat_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset abandons any burst in flight and empties the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      owner_q    <= 1'b0;
      prefer_q   <= 1'b0;
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ret_beat_q <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      owner_q    <= owner_d;
      prefer_q   <= prefer_d;
      tag_q      <= tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ret_beat_q <= ret_beat_d;
      perr_q     <= perr_d;
    end
  end

  assign owner          = owner_q;
  assign outstanding    = count_q;
  assign protocol_error = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_burst_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_burst_bus_arbiter
//  Purpose  : Scoreboard bench for burst_bus_arbiter with a memory-side
//             responder model and per-port read-data expectation queues.
//  Revision : 1.0  initial release
// ============================================================================
module tb_burst_bus_arbiter;

  logic       clk;
  logic       reset_n;
  logic       owner;
  logic [2:0] outstanding;
  logic       protocol_error;

  burst_bus_if #(.ADDR_W(24), .DATA_W(32)) m0_if ();
  burst_bus_if #(.ADDR_W(24), .DATA_W(32)) m1_if ();
  burst_bus_if #(.ADDR_W(24), .DATA_W(32)) mem_if ();

  burst_bus_arbiter #(
    .BURST_BEATS    (4),
    .MAX_OUTSTANDING(4),
    .FIXED_PRIORITY (0)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .m0            (m0_if),
    .m1            (m1_if),
    .mem           (mem_if),
    .owner         (owner),
    .outstanding   (outstanding),
    .protocol_error(protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Scoreboard queues
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  logic [23:0] wr_exp[$];
  logic [23:0] rd_pend[$];
  int          rd_due[$];
  logic [23:0] acc_addr[$];
  int          acc_cyc[$];
  int          ret_last_cyc[$];

  logic hold        = 1'b0;
  logic ret_busy    = 1'b0;
  int   inject_cnt  = 0;
  int   inject_done = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdat(input logic [23:0] a, input int b);
    return {a, 8'(b)} ^ 32'h5A00_0000;
  endfunction

  function automatic logic [31:0] wdat(input logic [23:0] a, input int b);
    return {8'(b + 8'hC0), a};
  endfunction

  function automatic logic [3:0] wmask(input logic [23:0] a, input int b);
    return 4'(a[3:0] + 4'(b) + 4'd1);
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic en, input logic c, input logic [23:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    if (p == 0) begin
      m0_if.cmd_en = en; m0_if.cmd = c; m0_if.addr = a; m0_if.wr_data = d; m0_if.data_mask = m;
    end else begin
      m1_if.cmd_en = en; m1_if.cmd = c; m1_if.addr = a; m1_if.wr_data = d; m1_if.data_mask = m;
    end
  endtask

  // Issue one command from port p; caller is at posedge+1. Returns at posedge+1
  // after the command (and any write beats) completes.
  task automatic issue(input int p, input logic wr, input logic [23:0] a, output int got_cyc);
    logic got;
    got     = 1'b0;
    got_cyc = -1;
    if (wr) begin
      wr_exp.push_back(a);
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (p == 0) exp0.push_back(rdat(a, b));
        else        exp1.push_back(rdat(a, b));
      end
    end
    drive(p, 1'b1, wr, a, wr ? wdat(a, 0) : 32'h0, wr ? wmask(a, 0) : 4'h0);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if ((p == 0) ? m0_if.ready : m1_if.ready) begin
        got     = 1'b1;
        got_cyc = cyc;
        break;
      end
    end
    if (!got) begin
      check($sformatf("accept_timeout_p%0d", p), 64'd0, 64'd1);
      drive(p, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
      return;
    end
    @(posedge clk);
    #1;
    drive(p, 1'b0, wr, a, 32'h0, 4'h0);
    if (wr) begin
      for (int b = 1; b < 4; b++) begin
        drive(p, 1'b0, 1'b1, a, wdat(a, b), wmask(a, b));
        @(posedge clk);
        #1;
      end
      drive(p, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    end
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (rd_pend.size() == 0 && exp0.size() == 0 && exp1.size() == 0 && !ret_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", 64'd0, 64'd1);
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory-side responder: logs accepts, checks write beats, queues reads.
  initial begin : slave_model
    int          wbeat;
    logic [23:0] waddr;
    logic [23:0] ea;
    wbeat = 0;
    waddr = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        wbeat = 0;
      end else begin
        if (wbeat > 0) begin
          check("wbeat_cmd_en", 64'(mem_if.cmd_en), 64'd0);
          check($sformatf("wr_beat%0d", wbeat), {mem_if.data_mask, mem_if.wr_data},
                {wmask(waddr, wbeat), wdat(waddr, wbeat)});
          wbeat = (wbeat == 3) ? 0 : wbeat + 1;
        end
        if (mem_if.cmd_en && mem_if.ready) begin
          acc_addr.push_back(mem_if.addr);
          acc_cyc.push_back(cyc);
          if (mem_if.cmd) begin
            if (wr_exp.size() == 0) begin
              check("wr_unexpected", 64'd1, 64'd0);
            end else begin
              ea = wr_exp.pop_front();
              check("wr_addr", 64'(mem_if.addr), 64'(ea));
            end
            check("wr_beat0", {mem_if.data_mask, mem_if.wr_data},
                  {wmask(mem_if.addr, 0), wdat(mem_if.addr, 0)});
            waddr = mem_if.addr;
            wbeat = 1;
          end else begin
            rd_pend.push_back(mem_if.addr);
            rd_due.push_back(cyc + 5);
          end
        end
      end
    end
  end

  // Memory-side read return driver (and protocol-error injection).
  initial begin : return_model
    logic [23:0] a;
    mem_if.rd_data_valid = 1'b0;
    mem_if.rd_data       = '0;
    forever begin
      @(posedge clk);
      #1;
      if (inject_cnt != inject_done) begin
        mem_if.rd_data_valid = 1'b1;
        mem_if.rd_data       = 32'hBAD0_0001;
        @(posedge clk);
        #1;
        mem_if.rd_data_valid = 1'b0;
        mem_if.rd_data       = '0;
        inject_done++;
      end else if (!hold && rd_pend.size() != 0 && cyc >= rd_due[0]) begin
        ret_busy = 1'b1;
        a = rd_pend.pop_front();
        void'(rd_due.pop_front());
        for (int b = 0; b < 4; b++) begin
          mem_if.rd_data_valid = 1'b1;
          mem_if.rd_data       = rdat(a, b);
          if (b == 3) ret_last_cyc.push_back(cyc);
          @(posedge clk);
          #1;
        end
        mem_if.rd_data_valid = 1'b0;
        mem_if.rd_data       = '0;
        ret_busy = 1'b0;
      end
    end
  end

  // Requester-side monitor: pops per-port expectations on each valid beat.
  initial begin : port_monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (m0_if.rd_data_valid) begin
        if (exp0.size() == 0) begin
          check("m0_rd_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp0.pop_front();
          check("m0_rd_data", 64'(m0_if.rd_data), 64'(e));
          check("m1_rd_bcast", 64'(m1_if.rd_data), 64'(e));
        end
      end
      if (m1_if.rd_data_valid) begin
        if (exp1.size() == 0) begin
          check("m1_rd_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp1.pop_front();
          check("m1_rd_data", 64'(m1_if.rd_data), 64'(e));
          check("m0_rd_bcast", 64'(m0_if.rd_data), 64'(e));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Directed test sequence
  initial begin : main
    int c0;
    int c1;
    int base;
    int rbase;
    logic [23:0] exp_order[$];

    reset_n = 1'b0;
    drive(0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    mem_if.ready = 1'b1;

    // Reset state, with a request presented to prove outputs are gated.
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b1, 24'h55, 32'h1234, 4'hF);
    @(negedge clk);
    check("rst_mem_cmd_en", 64'(mem_if.cmd_en), 64'd0);
    check("rst_mem_addr", 64'(mem_if.addr), 64'd0);
    check("rst_mem_wr_data", 64'(mem_if.wr_data), 64'd0);
    check("rst_m0_ready", 64'(m0_if.ready), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_perr", 64'(protocol_error), 64'd0);
    drive(0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    sync();
    reset_n = 1'b1;
    repeat (2) sync();

    // T1: single m0 read, zero added command latency.
    base = acc_addr.size();
    issue(0, 1'b0, 24'h100, c0);
    check("t1_acc_count", 64'(acc_addr.size() - base), 64'd1);
    if (acc_addr.size() > base) begin
      check("t1_acc_addr", 64'(acc_addr[base]), 64'h100);
      check("t1_acc_same_cycle", 64'(acc_cyc[base]), 64'(c0));
    end
    @(negedge clk);
    check("t1_outstanding_1", 64'(outstanding), 64'd1);
    check("t1_owner", 64'(owner), 64'd0);
    wait_idle();
    check("t1_outstanding_0", 64'(outstanding), 64'd0);

    // T2: both ports stream reads; round-robin alternates starting with m1.
    sync();
    base = acc_addr.size();
    fork
      begin
        for (int i = 0; i < 4; i++) issue(0, 1'b0, 24'h1000 + 24'(i * 16), c0);
      end
      begin
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 24'h2000 + 24'(i * 16), c1);
      end
    join
    for (int i = 0; i < 4; i++) begin
      exp_order.push_back(24'h2000 + 24'(i * 16));
      exp_order.push_back(24'h1000 + 24'(i * 16));
    end
    check("t2_acc_count", 64'(acc_addr.size() - base), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (base + k < acc_addr.size())
        check($sformatf("t2_order%0d", k), 64'(acc_addr[base + k]), 64'(exp_order[k]));
    end
    wait_idle();
    check("t2_outstanding_0", 64'(outstanding), 64'd0);

    // T3: m1 write vs m0 read; m1 wins, m0 held through beats 1..3.
    sync();
    base = acc_addr.size();
    fork
      issue(1, 1'b1, 24'h20, c1);
      issue(0, 1'b0, 24'h300, c0);
      begin
        @(negedge clk);
        @(negedge clk);
        check("t3_m0_ready_beat1", 64'(m0_if.ready), 64'd0);
        check("t3_mem_cmd_en_beat1", 64'(mem_if.cmd_en), 64'd0);
        check("t3_owner_m1", 64'(owner), 64'd1);
      end
    join
    check("t3_acc_count", 64'(acc_addr.size() - base), 64'd2);
    if (acc_addr.size() >= base + 2) begin
      check("t3_first_write", 64'(acc_addr[base]), 64'h20);
      check("t3_second_read", 64'(acc_addr[base + 1]), 64'h300);
      check("t3_read_delay", 64'(acc_cyc[base + 1] - acc_cyc[base]), 64'd4);
    end
    wait_idle();

    // T4: fill the tag FIFO; 5th read waits, a write still passes.
    hold = 1'b1;
    sync();
    for (int i = 0; i < 4; i++) issue(0, 1'b0, 24'h400 + 24'(i * 16), c0);
    @(negedge clk);
    check("t4_outstanding_full", 64'(outstanding), 64'd4);
    sync();
    base  = acc_addr.size();
    rbase = ret_last_cyc.size();
    fork
      issue(0, 1'b0, 24'h480, c0);
      begin
        issue(1, 1'b1, 24'h40, c1);
        repeat (2) @(negedge clk);
        check("t4_m0_held_ready", 64'(m0_if.ready), 64'd0);
        check("t4_only_write_acc", 64'(acc_addr.size() - base), 64'd1);
        hold = 1'b0;
      end
    join
    check("t4_acc_count", 64'(acc_addr.size() - base), 64'd2);
    if (acc_addr.size() >= base + 2 && ret_last_cyc.size() > rbase) begin
      check("t4_write_first", 64'(acc_addr[base]), 64'h40);
      check("t4_read5_on_pop", 64'(acc_cyc[base + 1]), 64'(ret_last_cyc[rbase]));
    end
    wait_idle();
    check("t4_outstanding_0", 64'(outstanding), 64'd0);

    // T5: read data with nothing outstanding is dropped and flags an error.
    sync();
    inject_cnt++;
    @(negedge clk);
    @(negedge clk);
    check("t5_m0_valid_dropped", 64'(m0_if.rd_data_valid), 64'd0);
    check("t5_m1_valid_dropped", 64'(m1_if.rd_data_valid), 64'd0);
    @(negedge clk);
    check("t5_perr_set", 64'(protocol_error), 64'd1);
    repeat (5) @(negedge clk);
    check("t5_perr_sticky", 64'(protocol_error), 64'd1);

    // T6: reset during write beat 2 abandons the burst.
    sync();
    fork
      issue(1, 1'b1, 24'h60, c1);
      begin
        @(negedge clk);
        sync();
        sync();
        reset_n = 1'b0;
        #1;
        check("t6_cmd_en", 64'(mem_if.cmd_en), 64'd0);
        check("t6_wr_data", 64'(mem_if.wr_data), 64'd0);
        check("t6_mask", 64'(mem_if.data_mask), 64'd0);
        check("t6_owner", 64'(owner), 64'd0);
        check("t6_outstanding", 64'(outstanding), 64'd0);
        check("t6_perr_cleared", 64'(protocol_error), 64'd0);
        sync();
        sync();
        reset_n = 1'b1;
      end
    join
    @(negedge clk);
    check("t6_no_more_beats", {63'd0, mem_if.cmd_en} | 64'(mem_if.wr_data), 64'd0);
    check("t6_outstanding_start", 64'(outstanding), 64'd0);
    sync();
    issue(0, 1'b0, 24'h500, c0);
    @(negedge clk);
    check("t6_outstanding_1", 64'(outstanding), 64'd1);
    wait_idle();
    check("t6_outstanding_0", 64'(outstanding), 64'd0);
    check("t6_perr_stays_clear", 64'(protocol_error), 64'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/burst_bus_arbiter.md
Name: burst_bus_arbiter

Overview:
- Shares one SDRAM burst_bus_if slave (memory controller side) between two burst_bus_if masters.
  - Port 0: video scanout reader.
  - Port 1: debug/CPU writer.
- Arbitrates commands and locks the bus for the data beats of a write burst.
- Tracks outstanding reads so returning rd_data beats reach the master that issued them.
- Sits between the framebuffer clients and the memory controller wrapper in the clk domain.

Parameters:
BURST_BEATS, 4, data beats per command (read or write), >=1
MAX_OUTSTANDING, 4, depth of read owner-tag FIFO, power of two
FIXED_PRIORITY, 0, 0 = round-robin between ports; 1 = port 0 always wins

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
m0  burst_bus_if.slave  intf  requester port 0
m1  burst_bus_if.slave  intf  requester port 1
mem  burst_bus_if.master  intf  toward memory controller
owner  output  1  port currently granted / last granted
outstanding  output  $clog2(MAX_OUTSTANDING)+1  read commands awaiting data
protocol_error  output  1  sticky; rd_data_valid arrived with no outstanding read

Behaviour:
- Protocol on every port:
  - cmd=1 write, cmd=0 read.
  - Command accepted in a cycle with cmd_en && ready.
  - Write: beat 0 of wr_data/data_mask in the accept cycle; beats 1..BURST_BEATS-1 on the following consecutive cycles, no backpressure.
  - Read: slave later returns BURST_BEATS rd_data_valid pulses, in command order.
  - Masters must not derive cmd_en from ready.
- Reset (async assert, sync deassert):
  - mem.cmd_en=0, mem.cmd=0, mem.addr=0, mem.wr_data=0, mem.data_mask=0.
  - m0/m1 ready=0, rd_data_valid=0, rd_data=0.
  - owner=0, outstanding=0, protocol_error=0.
  - FSM in IDLE, tag FIFO empty, round-robin pointer favours port 0.
  - Reset mid-burst abandons the burst; no further beats are forwarded.
- FSM states: IDLE, WRITE_BEATS.
- IDLE: a port is eligible if cmd_en=1 and (cmd=1 or tag FIFO not full).
  - Winner selection:
    - FIXED_PRIORITY=1: lowest eligible index wins.
    - FIXED_PRIORITY=0: if both are eligible, the port not granted last wins; a single eligible port always wins.
  - Winner sees ready = mem.ready, combinationally. Loser sees ready=0.
  - mem.cmd_en/cmd/addr/wr_data/data_mask are muxed combinationally from the winner, giving zero added command latency.
  - On accept (mem.ready && winner cmd_en):
    - owner <= winner; round-robin pointer updated.
    - Read: push winner index into tag FIFO; outstanding +1.
    - Write with BURST_BEATS>1: go to WRITE_BEATS, beat counter = 1.
- WRITE_BEATS:
  - Both ports ready=0, mem.cmd_en=0.
  - mem.wr_data/data_mask muxed from owner.
  - Counter increments each cycle; at BURST_BEATS-1 return to IDLE.
  - A new command can be accepted in the cycle after the last beat.
- Read return:
  - mem.rd_data is forwarded to both m0.rd_data and m1.rd_data, combinationally.
  - rd_data_valid is asserted only on the port at the tag FIFO head.
  - Return beat counter increments per valid beat. At beat BURST_BEATS-1, pop the FIFO; outstanding -1.
- Simultaneous push and pop in one cycle: outstanding is unchanged. A full FIFO may accept a new read in the same cycle it pops, since pop frees the slot combinationally.
- FIFO full: read requests are ineligible; a write from either port is still served.
- rd_data_valid with FIFO empty: beat dropped on both ports; protocol_error set, stays set until reset.
- outstanding never exceeds MAX_OUTSTANDING; pointers wrap modulo MAX_OUTSTANDING.

Test Plan:
- m0 read addr 0x100 alone, slave returns 4 beats D0..D3 after 5 cycles -> mem.cmd_en the same cycle; m0 gets 4 rd_data_valid with D0..D3; m1 gets none; outstanding goes 1 then 0.
- Both ports request reads every cycle, FIXED_PRIORITY=0 -> accepts alternate m0,m1,m0,m1; data returns routed in that order.
- m1 write addr 0x20 with beats W0..W3 while m0 requests a read -> m1 wins if last grant was m0. mem sees W0..W3 on 4 consecutive cycles; m0 ready=0 during beats 1-3; m0 read accepted on cycle 5.
- With slave withholding data, issue 4 reads from m0, then a 5th read and an m1 write -> 5th read held (ready=0); m1 write accepted; after first 4-beat return, 5th read accepted.
- Inject rd_data_valid with no reads outstanding -> no port sees valid; protocol_error=1 until reset_n low.
- Assert reset_n low on write beat 2 -> all outputs zero immediately; after release, a fresh m0 read completes normally with outstanding=0 at start.
